// File: rtl/spdif_tx_if.sv
// rtl/spdif_tx_if.sv - stereo sample handshake bundle for spdif_tx
// Purpose: groups the sample-pair valid/ready handshake into one port.
// Signals:
//   s_valid   master->slave  sample pair offered
//   s_ready   slave->master  buffer empty, pair will be accepted
//   s_left    master->slave  left sample, two's complement
//   s_right   master->slave  right sample, two's complement
//   s_invalid master->slave  validity flag for the pair (1 = not audio)
interface spdif_tx_if #(
  parameter int DATA_W = 24
);
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_left;
  logic [DATA_W-1:0] s_right;
  logic              s_invalid;

  modport master (output s_valid, s_left, s_right, s_invalid, input s_ready);
  modport slave  (input s_valid, s_left, s_right, s_invalid, output s_ready);
endinterface

// File: rtl/spdif_tx.sv
// rtl/spdif_tx.sv - parametrised S/PDIF (IEC 60958 consumer) biphase-mark transmitter
// Purpose: buffers one stereo pair, paces unit intervals with a fractional phase
//   accumulator and emits preambles plus biphase-mark coded subframes.
// Ports:
//   i_clk      system clock, rising edge
//   i_rst_n    asynchronous active-low reset
//   s_if       sample handshake (slave side)
//   o_spdif    biphase-mark line output
//   o_subframe 1 during right subframe
//   o_frame    toggles at every frame start
//   o_block    1 during frame 0 of the 192-frame block
//   o_underrun one-cycle pulse when a frame starts with an empty buffer
module spdif_tx #(
  parameter int          CLK_HZ    = 16000000,
  parameter int          SAMPLE_HZ = 48000,
  parameter int          DATA_W    = 24,
  parameter int          ACC_W     = 24,
  parameter logic [31:0] CS_LO     = 32'h0200_0004
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  spdif_tx_if.slave  s_if,
  output logic       o_spdif,
  output logic       o_subframe,
  output logic       o_frame,
  output logic       o_block,
  output logic       o_underrun
);
  localparam logic [63:0]      INC64 = ((64'(SAMPLE_HZ) * 64'd128) << ACC_W) / 64'(CLK_HZ);
  localparam logic [ACC_W-1:0] INC   = INC64[ACC_W-1:0];

  logic [ACC_W-1:0]  r_acc;
  logic [6:0]        r_ui;        // UI to be emitted on the next tick
  logic [7:0]        r_frame;
  logic              r_buf_full;
  logic [DATA_W-1:0] r_buf_l;
  logic [DATA_W-1:0] r_buf_r;
  logic              r_buf_inv;
  logic [DATA_W-1:0] r_frm_l;
  logic [DATA_W-1:0] r_frm_r;
  logic              r_frm_v;
  logic              r_pre_inv;   // line level just before the current preamble
  logic              r_spdif;
  logic              r_subframe;
  logic              r_frame_tgl;
  logic              r_block;
  logic              r_underrun;

  logic              w_tick;
  logic [ACC_W-1:0]  w_acc_nxt;
  logic              w_load;
  logic              w_hs;
  logic [4:0]        w_slot;
  logic [DATA_W-1:0] w_sample;
  logic [23:0]       w_audio;
  logic              w_c;
  logic              w_p;
  logic [31:0]       w_bits;
  logic [7:0]        w_pre_pat;
  logic              w_inv;
  logic              w_level;

  assign {w_tick, w_acc_nxt} = {1'b0, r_acc} + {1'b0, INC};
  assign w_load = w_tick && (r_ui == 7'd0);
  assign w_hs   = s_if.s_valid && !r_buf_full;

  // Slot-indexed view of the current subframe; slots 0..3 are preamble and unused here.
  assign w_slot    = r_ui[5:1];
  assign w_sample  = r_ui[6] ? r_frm_r : r_frm_l;
  assign w_audio   = 24'(w_sample) << (24 - DATA_W);
  assign w_c       = (r_frame < 8'd32) ? CS_LO[r_frame[4:0]] : 1'b0;
  assign w_p       = ^{w_c, r_frm_v, w_audio};
  assign w_bits    = {w_p, w_c, 1'b0, r_frm_v, w_audio, 4'b0000};

  assign w_pre_pat = r_ui[6] ? 8'b1110_0100 :
                     (r_frame == 8'd0) ? 8'b1110_1000 : 8'b1110_0010;
  // At the first preamble UI the preceding level is still on the line.
  assign w_inv     = (r_ui[5:0] == 6'd0) ? r_spdif : r_pre_inv;

  always_comb begin
    w_level = r_spdif;
    if (r_ui[5:3] == 3'd0) begin
      w_level = w_pre_pat[3'd7 - r_ui[2:0]] ^ w_inv;
    end else if (!r_ui[0]) begin
      w_level = ~r_spdif;
    end else begin
      w_level = r_spdif ^ w_bits[w_slot];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc       <= '0;
      r_ui        <= '0;
      r_frame     <= '0;
      r_buf_full  <= 1'b0;
      r_buf_l     <= '0;
      r_buf_r     <= '0;
      r_buf_inv   <= 1'b0;
      r_frm_l     <= '0;
      r_frm_r     <= '0;
      r_frm_v     <= 1'b0;
      r_pre_inv   <= 1'b0;
      r_spdif     <= 1'b0;
      r_subframe  <= 1'b0;
      r_frame_tgl <= 1'b0;
      r_block     <= 1'b1;
      r_underrun  <= 1'b0;
    end else begin
      r_acc      <= w_acc_nxt;
      r_underrun <= w_load && !r_buf_full;

      // Full buffer is emptied by a load; a same-cycle offer cannot occur then
      // because ready is low. An offer during an underrun load stays buffered.
      if (w_load && r_buf_full) begin
        r_buf_full <= 1'b0;
      end else if (w_hs) begin
        r_buf_full <= 1'b1;
        r_buf_l    <= s_if.s_left;
        r_buf_r    <= s_if.s_right;
        r_buf_inv  <= s_if.s_invalid;
      end

      if (w_tick) begin
        r_spdif <= w_level;
        r_ui    <= r_ui + 7'd1;
        if (r_ui == 7'd127) begin
          r_frame <= (r_frame == 8'd191) ? 8'd0 : r_frame + 8'd1;
        end
        if (r_ui[5:0] == 6'd0) begin
          r_pre_inv <= r_spdif;
        end
        if (r_ui == 7'd0) begin
          r_frame_tgl <= ~r_frame_tgl;
          r_subframe  <= 1'b0;
          r_block     <= (r_frame == 8'd0);
          if (r_buf_full) begin
            r_frm_l <= r_buf_l;
            r_frm_r <= r_buf_r;
            r_frm_v <= r_buf_inv;
          end else begin
            r_frm_l <= '0;
            r_frm_r <= '0;
            r_frm_v <= 1'b1;
          end
        end
        if (r_ui == 7'd64) begin
          r_subframe <= 1'b1;
        end
      end
    end
  end

  assign s_if.s_ready = ~r_buf_full;
  assign o_spdif      = r_spdif;
  assign o_subframe   = r_subframe;
  assign o_frame      = r_frame_tgl;
  assign o_block      = r_block;
  assign o_underrun   = r_underrun;
endmodule

// File: tb/tb_spdif_tx.sv
// tb/tb_spdif_tx.sv - self-checking bench for spdif_tx (24-bit and 16-bit instances)
module tb_spdif_tx;
  localparam int          CLK_HZ    = 16000000;
  localparam int          SAMPLE_HZ = 48000;
  localparam int          ACC_W     = 24;
  localparam logic [31:0] CS_LO     = 32'h0200_0004;
  localparam longint unsigned INC = ((64'(SAMPLE_HZ) * 64'd128) << ACC_W) / 64'(CLK_HZ);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spdif_tx_if #(.DATA_W(24)) if24();
  spdif_tx_if #(.DATA_W(16)) if16();
  assign if16.s_valid   = if24.s_valid;
  assign if16.s_left    = if24.s_left[15:0];
  assign if16.s_right   = if24.s_right[15:0];
  assign if16.s_invalid = if24.s_invalid;

  wire [1:0] w_spdif, w_sub, w_frm, w_blk, w_und;

  spdif_tx #(.CLK_HZ(CLK_HZ), .SAMPLE_HZ(SAMPLE_HZ), .DATA_W(24), .ACC_W(ACC_W), .CS_LO(CS_LO)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .s_if(if24.slave),
    .o_spdif(w_spdif[0]), .o_subframe(w_sub[0]), .o_frame(w_frm[0]),
    .o_block(w_blk[0]), .o_underrun(w_und[0]));

  spdif_tx #(.CLK_HZ(CLK_HZ), .SAMPLE_HZ(SAMPLE_HZ), .DATA_W(16), .ACC_W(ACC_W), .CS_LO(CS_LO)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .s_if(if16.slave),
    .o_spdif(w_spdif[1]), .o_subframe(w_sub[1]), .o_frame(w_frm[1]),
    .o_block(w_blk[1]), .o_underrun(w_und[1]));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model state
  longint m_cyc;
  int     m_ui, m_frame, m_starts;
  bit     m_full, m_binv;
  logic [23:0] m_bl, m_br;
  bit     wave [2][128];
  bit     m_spdif [2];
  bit     m_sub, m_frm, m_blk, m_und;
  bit     hs_seen, last_tick;
  int     last_ui, last_fr, last_starts;
  int     phase = 0;
  bit     cap [2][5][128];
  int     tog_cnt = 0, blk_cnt = 0, und_cnt = 0;
  logic   prev_frm = 1'b0;

  function automatic bit tick_at(longint n);
    return ((longint'(n + 1) * INC) >> ACC_W) != ((longint'(n) * INC) >> ACC_W);
  endfunction

  // Build the 128 UI levels of one frame from the frame-format rules.
  task automatic build_wave(input int k, input logic [23:0] l24, input logic [23:0] r24,
                            input bit v, input bit prev_lvl, input int fr);
    bit lvl, inv, c;
    logic [23:0] smp, aud;
    logic [27:0] bits;
    logic [7:0]  pat;
    logic [31:0] cs;
    cs  = CS_LO;
    lvl = prev_lvl;
    c   = (fr < 32) ? cs[fr] : 1'b0;
    for (int sf = 0; sf < 2; sf++) begin
      smp  = (sf == 1) ? r24 : l24;
      aud  = (k == 0) ? smp : {smp[15:0], 8'h00};
      bits = {1'b0, c, 1'b0, v, aud};
      bits[27] = ^bits[26:0];
      pat  = (sf == 1) ? 8'b1110_0100 : ((fr == 0) ? 8'b1110_1000 : 8'b1110_0010);
      inv  = lvl;
      for (int u = 0; u < 64; u++) begin
        if (u < 8)             lvl = pat[7-u] ^ inv;
        else if (u % 2 == 0)   lvl = ~lvl;
        else                   lvl = lvl ^ bits[u/2 - 4];
        wave[k][sf*64 + u] = lvl;
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cyc = 0; m_ui = 0; m_frame = 0; m_starts = 0; m_full = 0;
      m_spdif[0] = 0; m_spdif[1] = 0;
      m_sub = 0; m_frm = 0; m_blk = 1; m_und = 0;
      hs_seen = 0; last_tick = 0;
    end else begin
      bit tk, hs;
      tk = tick_at(m_cyc);
      m_cyc++;
      hs = if24.s_valid && !m_full;
      m_und = 0;
      last_tick = tk;
      if (tk) begin
        if (m_ui == 0) begin
          for (int k = 0; k < 2; k++) begin
            if (m_full) build_wave(k, m_bl, m_br, m_binv, m_spdif[k], m_frame);
            else        build_wave(k, 24'h0, 24'h0, 1'b1, m_spdif[k], m_frame);
          end
          if (m_full) m_full = 0;
          else        m_und = 1;
          m_frm = ~m_frm; m_sub = 0; m_blk = (m_frame == 0);
          m_starts++;
        end
        if (m_ui == 64) m_sub = 1;
        for (int k = 0; k < 2; k++) m_spdif[k] = wave[k][m_ui];
        last_ui = m_ui; last_fr = m_frame; last_starts = m_starts;
        m_ui++;
        if (m_ui == 128) begin
          m_ui = 0;
          m_frame = (m_frame == 191) ? 0 : m_frame + 1;
        end
      end
      if (hs) begin
        m_full = 1; m_bl = if24.s_left; m_br = if24.s_right; m_binv = if24.s_invalid;
      end
      hs_seen = hs;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 2; k++) begin
        check("spdif", w_spdif[k], m_spdif[k]);
        check("subframe", w_sub[k], m_sub);
        check("frame", w_frm[k], m_frm);
        check("block", w_blk[k], m_blk);
        check("underrun", w_und[k], m_und);
        check("s_ready", (k == 0) ? if24.s_ready : if16.s_ready, !m_full);
        if (last_tick) begin
          if (phase == 0 && last_starts <= 4 && last_fr < 4) cap[k][last_fr][last_ui] = w_spdif[k];
          if (phase == 1 && last_starts == 1) cap[k][4][last_ui] = w_spdif[k];
        end
      end
      if (phase == 0) begin
        if (w_frm[0] !== prev_frm) begin
          tog_cnt++;
          if (w_blk[0] === 1'b1) blk_cnt++;
        end
        prev_frm = w_frm[0];
        if (w_und[0] === 1'b1) und_cnt++;
      end
    end
  end

  logic [48:0] q [$];
  bit feed_rand = 0;

  task automatic drive(input logic [48:0] pr);
    if24.s_left = pr[48:25]; if24.s_right = pr[24:1]; if24.s_invalid = pr[0];
    if24.s_valid = 1'b1;
  endtask

  task automatic step();
    logic [48:0] pr;
    @(negedge clk);
    if (!rst_n) begin
      if24.s_valid = 1'b0;
    end else begin
      if (hs_seen) if24.s_valid = 1'b0;
      if (!if24.s_valid) begin
        if (q.size() > 0) begin
          pr = q.pop_front();
          drive(pr);
        end else if (feed_rand) begin
          pr = {24'($urandom), 24'($urandom), 1'($urandom_range(0, 1))};
          drive(pr);
        end
      end
    end
  endtask

  task automatic wait_frame(input int starts, input int ui_min, input int budget, input string tag);
    int n = 0;
    while (!(m_starts >= starts && m_ui >= ui_min) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) check({tag, "_timeout"}, 1, 0);
  endtask

  task automatic check_reset_vals(input string tag);
    for (int k = 0; k < 2; k++) begin
      check({tag, "_spdif"}, w_spdif[k], 0);
      check({tag, "_subframe"}, w_sub[k], 0);
      check({tag, "_frame"}, w_frm[k], 0);
      check({tag, "_block"}, w_blk[k], 1);
      check({tag, "_underrun"}, w_und[k], 0);
      check({tag, "_ready"}, (k == 0) ? if24.s_ready : if16.s_ready, 1);
    end
  endtask

  function automatic logic [27:0] dec(int k, int s, int base);
    logic [27:0] d;
    for (int sl = 4; sl < 32; sl++) d[sl-4] = cap[k][s][base + 2*sl] ^ cap[k][s][base + 2*sl + 1];
    return d;
  endfunction

  function automatic logic [7:0] pre(int k, int s, int base);
    logic [7:0] p;
    for (int u = 0; u < 8; u++) p[7-u] = cap[k][s][base + u];
    return p;
  endfunction

  initial begin
    int n;
    if24.s_valid = 0; if24.s_left = 0; if24.s_right = 0; if24.s_invalid = 0;
    repeat (3) @(negedge clk);
    check_reset_vals("rst");

    q.push_back({24'h000000, 24'h000000, 1'b0});
    q.push_back({24'h800001, 24'($urandom), 1'b0});
    q.push_back({24'h008001, 24'($urandom), 1'b0});
    rst_n = 1'b1;

    // Queue runs dry after the third pair: frames 3..6 underrun.
    wait_frame(7, 1, 3000, "frame6");
    repeat (2) step();
    check("underrun_count", und_cnt, 4);
    feed_rand = 1;
    wait_frame(8, 1, 1000, "frame7");
    repeat (2) step();
    check("underrun_resume", und_cnt, 4);

    wait_frame(193, 1, 70000, "frame192");
    repeat (2) step();
    check("frame_toggles", tog_cnt, 193);
    check("block_frames", blk_cnt, 2);

    // Mid-frame asynchronous reset at UI 40 of frame 5 of the new block.
    wait_frame(198, 41, 3000, "frame5");
    #2 rst_n = 1'b0;
    #1 check_reset_vals("async_rst");
    phase = 1;
    q.delete();
    feed_rand = 0;
    repeat (3) step();
    rst_n = 1'b1;
    feed_rand = 1;
    wait_frame(2, 1, 1000, "post_rst");
    repeat (2) step();

    check("pre_b_f0", pre(0, 0, 0), 8'hE8);
    check("pre_w_f0", pre(0, 0, 64), 8'hE4 ^ {8{cap[0][0][63]}});
    check("pre_m_f1", pre(0, 1, 0), 8'hE2 ^ {8{cap[0][0][127]}});
    check("data_f0_l", dec(0, 0, 0), 28'h0000000);
    check("data_f0_r", dec(0, 0, 64), 28'h0000000);
    check("data_f1_l24", dec(0, 1, 0), 28'h0800001);
    check("data_f2_l16", dec(1, 2, 0), 28'hC800100);
    check("data_f3_und", dec(0, 3, 0), 28'h9000000);
    check("pre_b_rst0", pre(0, 4, 0), 8'hE8);
    check("pre_b_rst1", pre(1, 4, 0), 8'hE8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
